// File: rtl/pos_cache_mu_broadcast_ctrl.sv
// Motion-update broadcast controller: round-robin arbitration of NUM_SRC motion-update
// units onto the shared bus that feeds every double-buffered position cache.
module pos_cache_mu_broadcast_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_SRC       = 4,
    parameter int SRC_ID_WIDTH  = 2,
    parameter int COUNT_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [NUM_SRC-1:0]                   i_src_valid,
    input  logic [NUM_SRC*3*DATA_WIDTH-1:0]      i_src_data,
    input  logic [NUM_SRC*3*CELL_ID_WIDTH-1:0]   i_src_dst_cell,
    input  logic [NUM_SRC-1:0]                   i_src_done,
    output logic [NUM_SRC-1:0]                   o_src_ready,
    output logic                                 o_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              o_out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           o_out_data_dst_cell,
    output logic                                 o_out_data_valid,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [COUNT_WIDTH-1:0]               o_particle_count,
    output logic                                 o_count_overflow
);

    localparam int PW  = 3 * DATA_WIDTH;
    localparam int CW  = 3 * CELL_ID_WIDTH;
    localparam int STW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENABLE,
        S_BROADCAST,
        S_DRAIN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [SRC_ID_WIDTH-1:0]  r_rr_ptr;
    logic [SRC_ID_WIDTH-1:0]  w_grant;
    logic [SRC_ID_WIDTH-1:0]  w_grant_next;
    logic                     w_found;
    logic                     w_xfer;
    logic                     w_phase_end;
    logic [PW-1:0]            w_sel_data;
    logic [CW-1:0]            w_sel_cell;
    logic [STW-1:0]           r_settle_cnt;
    int                       w_scan_idx;

    // Search starts at the round-robin pointer so the last-served source drops to lowest priority.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_sel_data = '0;
        w_sel_cell = '0;
        w_scan_idx = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_SRC) begin
                w_scan_idx = w_scan_idx - NUM_SRC;
            end
            if (!w_found && i_src_valid[w_scan_idx]) begin
                w_found    = 1'b1;
                w_grant    = SRC_ID_WIDTH'(w_scan_idx);
                w_sel_data = i_src_data[w_scan_idx*PW +: PW];
                w_sel_cell = i_src_dst_cell[w_scan_idx*CW +: CW];
            end
        end
    end

    assign w_xfer       = (r_state == S_BROADCAST) && w_found;
    assign w_phase_end  = (&i_src_done) && !(|i_src_valid);
    assign w_grant_next = (w_grant == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        o_src_ready = '0;
        if (w_xfer) begin
            o_src_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next_state = S_ENABLE;
            S_ENABLE:    w_next_state = S_BROADCAST;
            S_BROADCAST: if (w_phase_end) w_next_state = S_DRAIN;
            S_DRAIN:     w_next_state = S_SETTLE;
            S_SETTLE:    if (r_settle_cnt == STW'(SETTLE_CYCLES - 1)) w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Phase outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_motion_update_enable <= 1'b0;
            o_out_data             <= '0;
            o_out_data_dst_cell    <= '0;
            o_out_data_valid       <= 1'b0;
            o_busy                 <= 1'b0;
            o_done                 <= 1'b0;
            o_particle_count       <= '0;
            o_count_overflow       <= 1'b0;
            r_rr_ptr               <= '0;
            r_settle_cnt           <= '0;
        end else begin
            o_motion_update_enable <= (w_next_state == S_ENABLE) || (w_next_state == S_BROADCAST)
                                      || (w_next_state == S_DRAIN);
            o_busy                 <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            o_done                 <= (w_next_state == S_DONE);
            o_out_data_valid       <= w_xfer;
            o_out_data             <= w_xfer ? w_sel_data : '0;
            o_out_data_dst_cell    <= w_xfer ? w_sel_cell : '0;
            r_settle_cnt           <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;
            if ((r_state == S_IDLE) && i_start) begin
                o_particle_count <= '0;
                o_count_overflow <= 1'b0;
            end else if (w_xfer) begin
                r_rr_ptr <= w_grant_next;
                // Saturate rather than wrap; the particle is still broadcast.
                if (&o_particle_count) begin
                    o_count_overflow <= 1'b1;
                end else begin
                    o_particle_count <= o_particle_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pos_cache_mu_broadcast_ctrl.sv
// Self-checking bench for pos_cache_mu_broadcast_ctrl: directed vector table plus
// model-checked phases with round-robin prediction and a narrow-counter second instance.
module tb_pos_cache_mu_broadcast_ctrl;

    localparam int NS     = 4;
    localparam int PW     = 96;
    localparam int CW     = 12;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start;
    logic [NS-1:0]   srcValid, srcDone;
    logic [NS*PW-1:0] srcData;
    logic [NS*CW-1:0] srcCell;

    logic [NS-1:0]   srcReady, sReady;
    logic            muEnable, outValid, busy, done, ovf;
    logic            sEnable, sOutValid, sBusy, sDone, sOvf;
    logic [PW-1:0]   outData, sOutData;
    logic [CW-1:0]   outCell, sOutCell;
    logic [15:0]     pCount;
    logic [3:0]      sCount;

    pos_cache_mu_broadcast_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_src_valid(srcValid),
        .i_src_data(srcData), .i_src_dst_cell(srcCell), .i_src_done(srcDone),
        .o_src_ready(srcReady), .o_motion_update_enable(muEnable), .o_out_data(outData),
        .o_out_data_dst_cell(outCell), .o_out_data_valid(outValid), .o_busy(busy),
        .o_done(done), .o_particle_count(pCount), .o_count_overflow(ovf)
    );

    pos_cache_mu_broadcast_ctrl #(.COUNT_WIDTH(4)) dutNarrow (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_src_valid(srcValid),
        .i_src_data(srcData), .i_src_dst_cell(srcCell), .i_src_done(srcDone),
        .o_src_ready(sReady), .o_motion_update_enable(sEnable), .o_out_data(sOutData),
        .o_out_data_dst_cell(sOutCell), .o_out_data_valid(sOutValid), .o_busy(sBusy),
        .o_done(sDone), .o_particle_count(sCount), .o_count_overflow(sOvf)
    );

    int nChecks = 0;
    int nPass   = 0;
    int mRr     = 0;
    int beatsSeen, firstBeatCyc, lastBeatCyc, phaseEdges, lastExpCount;

    typedef struct {
        logic          start;
        logic [NS-1:0] valid;
        logic [NS-1:0] doneIn;
        logic [NS-1:0] expReady;
        logic          expEn;
        logic          expDv;
        logic          expBusy;
        logic          expDone;
        int            dataRow;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [PW-1:0] mkData(input int s, input int k);
        return {32'(s * 1000 + k), 32'(k * 7 + 3), 32'(32'hCAFE0000 + s)};
    endfunction

    function automatic logic [CW-1:0] mkCell(input int s, input int k);
        return {4'(s), 4'(k), 4'(k + 1)};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic [NS-1:0] v, input logic [NS-1:0] d);
        start    = st;
        srcValid = v;
        srcDone  = d;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // One full motion-update phase checked against a round-robin model.
    // mode 0: random valid; mode 1: valid whenever a source still has particles.
    task automatic runPhase(input int mode, input int perSrc, input int onlySrc);
        int remaining[NS];
        int sentIdx[NS];
        logic [NS-1:0] v, d, expReady;
        logic          expValid;
        logic [PW-1:0] expData;
        logic [CW-1:0] expCell;
        int            expCount, g, idx, cyc;
        bit            ended;
        expValid = 1'b0; expData = '0; expCell = '0; expCount = 0; ended = 0; cyc = 0;
        beatsSeen = 0; firstBeatCyc = -1; lastBeatCyc = -1; phaseEdges = 0;
        for (int i = 0; i < NS; i++) begin
            remaining[i] = (onlySrc < 0 || onlySrc == i) ? perSrc : 0;
            sentIdx[i]   = 0;
            d[i]         = (remaining[i] == 0);
            v[i]         = (remaining[i] > 0);
        end
        applyStimulus(1'b1, '0, d);
        stepClk();
        checkOutput("enable_after_start", muEnable, 1);
        checkOutput("count_cleared", pCount, 0);
        checkOutput("narrow_count_cleared", {sOvf, sCount}, 0);
        applyStimulus(1'b0, v, d);
        #1;
        checkOutput("ready_in_enable", srcReady, 0);
        stepClk(); phaseEdges++;
        while (!ended && cyc < 500) begin
            checkOutput("beat_valid", outValid, expValid);
            checkOutput("narrow_beat_valid", sOutValid, expValid);
            checkOutput("bcast_enable", muEnable, 1);
            if (expValid) begin
                checkOutput("beat_data", outData, expData);
                checkOutput("beat_cell", outCell, expCell);
                checkOutput("narrow_beat_data", {sOutData, sOutCell}, {expData, expCell});
            end
            if (outValid === 1'b1) begin
                beatsSeen++;
                if (firstBeatCyc < 0) firstBeatCyc = cyc;
                lastBeatCyc = cyc;
            end
            for (int i = 0; i < NS; i++) begin
                v[i] = (remaining[i] > 0) && (mode != 0 || $urandom_range(0, 1) == 1);
                d[i] = (remaining[i] == 0);
                srcData[i*PW +: PW] = mkData(i, sentIdx[i]);
                srcCell[i*CW +: CW] = mkCell(i, sentIdx[i]);
            end
            applyStimulus(1'b0, v, d);
            #1;
            g = -1;
            for (int k = 0; k < NS; k++) begin
                idx = (mRr + k) % NS;
                if (g < 0 && v[idx]) g = idx;
            end
            expReady = (g < 0) ? '0 : NS'(1 << g);
            checkOutput("src_ready", srcReady, expReady);
            checkOutput("narrow_src_ready", sReady, expReady);
            if (g >= 0) begin
                expValid = 1'b1;
                expData  = mkData(g, sentIdx[g]);
                expCell  = mkCell(g, sentIdx[g]);
                sentIdx[g]++;
                remaining[g]--;
                mRr = (g + 1) % NS;
                expCount++;
            end else begin
                expValid = 1'b0;
            end
            if (v == '0 && d == '1) ended = 1;
            stepClk(); phaseEdges++; cyc++;
        end
        if (!ended) checkOutput("phase_end_timeout", 0, 1);
        checkOutput("drain_enable", muEnable, 1);
        checkOutput("drain_valid", outValid, 0);
        applyStimulus(1'b0, '0, d);
        cyc = 0;
        while (cyc < 20) begin
            stepClk(); phaseEdges++; cyc++;
            if (done === 1'b1) break;
            checkOutput("settle_quiet", {muEnable, outValid, busy}, 3'b001);
        end
        checkOutput("settle_length", cyc, SETTLE + 1);
        checkOutput("done_state", {done, busy, muEnable}, 3'b100);
        checkOutput("narrow_done", sDone, 1);
        checkOutput("count", pCount, expCount);
        checkOutput("ovf", ovf, 0);
        checkOutput("narrow_count", sCount, (expCount > 15) ? 15 : expCount);
        checkOutput("narrow_ovf", sOvf, expCount > 15);
        lastExpCount = expCount;
        stepClk();
        checkOutput("done_pulse_width", {done, busy, sDone, sBusy, sEnable}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        srcData = '0;
        srcCell = '0;
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0);
        stepClk(); stepClk();
        rst = 1'b0;
        checkOutput("reset_outputs", {muEnable, outValid, busy, done, ovf, srcReady}, 0);
        checkOutput("reset_data", {outData, outCell, pCount}, 0);

        // Reset in BROADCAST with particles still pending.
        srcData[0 +: PW] = mkData(0, 0);
        srcCell[0 +: CW] = mkCell(0, 0);
        applyStimulus(1'b1, '0, '0);
        stepClk();
        applyStimulus(1'b0, 4'b0001, '0);
        stepClk(); stepClk(); stepClk();
        rst = 1'b1;
        stepClk();
        checkOutput("midphase_reset_ctrl", {muEnable, outValid, busy, done, ovf, srcReady}, 0);
        checkOutput("midphase_reset_data", {outData, outCell, pCount}, 0);
        rst = 1'b0;
        mRr = 0;
        applyStimulus(1'b0, '0, '0);
        stepClk();

        // All sources streaming: strict 0,1,2,3 rotation with no bubbles.
        runPhase(1, 8, -1);
        checkOutput("all4_beats", beatsSeen, 32);
        checkOutput("all4_no_bubbles", lastBeatCyc - firstBeatCyc + 1, 32);

        runPhase(0, 10, -1);
        checkOutput("random_beats", beatsSeen, 40);

        // Directed single-source phase; a stray start during SETTLE must be ignored.
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, -1};
        vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, -1};
        vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        vecs[4]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4};
        vecs[5]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, -1};
        vecs[6]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        vecs[7]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        vecs[8]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        vecs[9]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        vecs[10] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        vecs[11] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        for (int r = 0; r < 12; r++) begin
            srcData[0 +: PW] = mkData(0, r);
            srcCell[0 +: CW] = 12'h421;
            applyStimulus(vecs[r].start, vecs[r].valid, vecs[r].doneIn);
            #1;
            checkOutput($sformatf("vec%0d_ready", r), srcReady, vecs[r].expReady);
            stepClk();
            checkOutput($sformatf("vec%0d_ctrl", r), {muEnable, outValid, busy, done},
                        {vecs[r].expEn, vecs[r].expDv, vecs[r].expBusy, vecs[r].expDone});
            if (vecs[r].dataRow >= 0) begin
                checkOutput($sformatf("vec%0d_data", r), {outData, outCell},
                            {mkData(0, vecs[r].dataRow), 12'h421});
            end
        end
        checkOutput("vec_count", pCount, 3);
        mRr = 1;

        // No particles at all: done lands 7 edges after the start edge.
        runPhase(1, 0, -1);
        checkOutput("zero_beats", beatsSeen, 0);
        checkOutput("zero_done_latency", phaseEdges, 7);

        // 20 particles into the 4-bit counter instance: saturates yet broadcasts all.
        runPhase(1, 20, 2);
        checkOutput("ovf_beats", beatsSeen, 20);
        checkOutput("ovf_main_count", lastExpCount, 20);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
